// File: rtl/alu_vec_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : alu_vec_seq
// Purpose  : Vector element sequencer that drives an external combinational
//            32-bit ALU and returns one registered result per element.
// Revision : 1.0 - initial release
// ============================================================================
module alu_vec_seq #(
    parameter int MAX_VL = 16,
    parameter int VL_W   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    // command channel
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [3:0]      cmd_ctl,
    input  logic [VL_W-1:0] cmd_vl,
    input  logic            cmd_bcast,
    input  logic [31:0]     cmd_bval,
    // element operand stream
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_a,
    input  logic [31:0]     in_b,
    // external ALU
    output logic [3:0]      alu_ctl,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    input  logic [31:0]     alu_out,
    input  logic            alu_zero,
    // result stream
    output logic            res_valid,
    input  logic            res_ready,
    output logic [31:0]     res_data,
    output logic            res_last,
    // status
    output logic            busy,
    output logic            done,
    output logic            all_zero
);

    localparam logic [VL_W-1:0] c_MAX_VL = VL_W'(MAX_VL);
    localparam logic [VL_W-1:0] c_ONE    = VL_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [3:0]      r_ctl;
    logic [VL_W-1:0] r_vl;
    logic            r_bcast;
    logic [31:0]     r_bval;
    logic [VL_W-1:0] r_cnt;

    logic            r_res_valid;
    logic [31:0]     r_res_data;
    logic            r_res_last;
    logic            r_all_zero;

    logic [VL_W-1:0] w_vl_eff;
    logic            w_in_ready;
    logic            w_cmd_fire;
    logic            w_in_fire;
    logic            w_last_elem;
    logic            w_res_take;

    assign w_vl_eff    = (cmd_vl > c_MAX_VL) ? c_MAX_VL : cmd_vl;
    // A single output register still sustains one element per cycle because
    // a result being consumed this cycle frees the slot for the next one.
    assign w_in_ready  = (r_state == S_RUN) & (~r_res_valid | res_ready);
    assign w_cmd_fire  = cmd_valid & (r_state == S_IDLE);
    assign w_in_fire   = in_valid & w_in_ready;
    assign w_last_elem = (r_cnt == (r_vl - c_ONE));
    assign w_res_take  = r_res_valid & res_ready;

    assign cmd_ready = (r_state == S_IDLE);
    assign in_ready  = w_in_ready;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);

    assign alu_ctl = r_ctl;
    assign alu_a   = in_a;
    assign alu_b   = r_bcast ? r_bval : in_b;

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_last  = r_res_last;
    assign all_zero  = r_all_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    w_next = (w_vl_eff != '0) ? S_RUN : S_FIN;
                end
            end
            S_RUN: begin
                if (w_in_fire && w_last_elem) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_res_take && r_res_last) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl       <= '0;
            r_vl        <= '0;
            r_bcast     <= 1'b0;
            r_bval      <= '0;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_last  <= 1'b0;
            r_all_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_ctl      <= cmd_ctl;
                        r_vl       <= w_vl_eff;
                        r_bcast    <= cmd_bcast;
                        r_bval     <= cmd_bval;
                        r_cnt      <= '0;
                        r_all_zero <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_in_fire) begin
                        r_res_data  <= alu_out;
                        r_res_valid <= 1'b1;
                        r_res_last  <= w_last_elem;
                        r_all_zero  <= r_all_zero & alu_zero;
                        r_cnt       <= r_cnt + c_ONE;
                    end else if (res_ready) begin
                        r_res_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // Only the final result can be pending here.
                    if (w_res_take && r_res_last) begin
                        r_res_valid <= 1'b0;
                        r_res_last  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
